// File: rtl/inst_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: state encoding and fetch constants.
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FLOW  = 2'd1,
        ST_HOLD  = 2'd2
    } fetch_state_e;

    localparam int unsigned PC_STEP           = 32'd4;
    localparam logic [31:0] DEFAULT_HALT_WORD = 32'h0000_000C;

endpackage

// File: rtl/inst_fetch.sv
// Instruction fetch: owns the PC, drives the synchronous ROM and hands words to decode.
// Optional halt-on-HALT_WORD behaviour is enabled by defining INST_FETCH_HALT_EN.
module inst_fetch
    import inst_fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] HALT_WORD  = DATA_WIDTH'(DEFAULT_HALT_WORD)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_inst,
    output logic [ADDR_WIDTH-1:0] out_pc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  halted
);

`ifdef INST_FETCH_HALT_EN
    localparam logic HALT_EN = 1'b1;
`else
    localparam logic HALT_EN = 1'b0;
`endif

    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_f_q, pc_f_d;
    logic [ADDR_WIDTH-1:0] pc_d_q, pc_d_d;
    logic [DATA_WIDTH-1:0] hold_inst_q, hold_inst_d;
    logic                  halted_q, halted_d;

    logic [ADDR_WIDTH-1:0] rom_addr_s;
    logic                  issue_s;
    logic                  out_valid_s;
    logic [DATA_WIDTH-1:0] out_inst_s;
    logic                  halt_take_s;

    // Address select, issue decision and the decode-facing view of the current word.
    always_comb begin
        rom_addr_s  = redirect_valid ? {redirect_pc[ADDR_WIDTH-1:2], 2'b00} : pc_f_q;
        issue_s     = redirect_valid |
                      (~halted_q & ((state_q == ST_EMPTY) | out_ready));
        out_valid_s = (state_q == ST_FLOW) | (state_q == ST_HOLD);
        out_inst_s  = (state_q == ST_FLOW) ? rom_data : hold_inst_q;
        halt_take_s = HALT_EN & out_valid_s & out_ready & (out_inst_s == HALT_WORD);
    end

    // Next-state logic: PC advance on issue, hold capture on stall, redirect overrides all.
    always_comb begin
        state_d     = state_q;
        pc_f_d      = pc_f_q;
        pc_d_d      = pc_d_q;
        hold_inst_d = hold_inst_q;
        halted_d    = halted_q;

        if (issue_s) begin
            pc_d_d = rom_addr_s;
            pc_f_d = rom_addr_s + ADDR_WIDTH'(PC_STEP);
        end else begin
            pc_d_d = pc_d_q;
            pc_f_d = pc_f_q;
        end

        if (redirect_valid) begin
            state_d  = ST_FLOW;
            halted_d = 1'b0;
        end else if (halt_take_s) begin
            // The word fetched behind the halt word is dropped.
            state_d  = ST_EMPTY;
            halted_d = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    state_d = issue_s ? ST_FLOW : ST_EMPTY;
                end
                ST_FLOW: begin
                    if (out_ready) begin
                        state_d = issue_s ? ST_FLOW : ST_EMPTY;
                    end else begin
                        hold_inst_d = rom_data;
                        state_d     = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state_d = issue_s ? ST_FLOW : ST_EMPTY;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                end
            endcase
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_EMPTY;
            pc_f_q      <= RESET_PC;
            pc_d_q      <= '0;
            hold_inst_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_f_q      <= pc_f_d;
            pc_d_q      <= pc_d_d;
            hold_inst_q <= hold_inst_d;
            halted_q    <= halted_d;
        end
    end

    assign rom_addr  = rom_addr_s;
    assign out_valid = out_valid_s;
    assign out_inst  = out_inst_s;
    assign out_pc    = pc_d_q;
    assign halted    = halted_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized bench for inst_fetch against a stream-level model of the expected instruction sequence.
module tb_inst_fetch;

`ifdef INST_FETCH_HALT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif
    localparam logic [31:0] HALT_WORD_TB = 32'h0000_000C;
    localparam logic [31:0] RESET_PC_TB  = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] rom_addr;
    logic [31:0] rom_data = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halted;

    logic [31:0] rom_mem [0:1023];

    int checks   = 0;
    int failures = 0;

    // Stream model: the pc of the word decode should see, and whether one is being shown.
    bit          m_valid;
    bit          m_halted;
    logic [31:0] m_pc;

    inst_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_inst       (out_inst),
        .out_pc         (out_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halted         (halted)
    );

    always #5 clk = ~clk;

    // Synchronous ROM, one-cycle read latency, word index from address bits [11:2].
    always @(posedge clk) begin
        rom_data <= rom_mem[rom_addr[11:2]];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_halted = 1'b0;
        m_pc     = RESET_PC_TB;
    endtask

    // One cycle: entered at a negedge, drives inputs, checks, advances model, leaves at next negedge.
    task automatic step(input bit rdy, input bit rv, input logic [31:0] rpc);
        logic [31:0] word;
        out_ready      = rdy;
        redirect_valid = rv;
        redirect_pc    = rpc;
        #1;
        chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
        chk("halted", {31'b0, halted}, {31'b0, m_halted});
        if (m_valid) begin
            chk("out_pc", out_pc, m_pc);
            chk("out_inst", out_inst, rom_mem[m_pc[11:2]]);
        end
        if (rv)
            chk("rom_addr_redir", rom_addr, {rpc[31:2], 2'b00});
        else if (m_valid)
            chk("rom_addr_next", rom_addr, m_pc + 32'd4);
        else if (!m_halted)
            chk("rom_addr_empty", rom_addr, m_pc);
        word = rom_mem[m_pc[11:2]];
        @(posedge clk);
        if (rv) begin
            m_pc     = {rpc[31:2], 2'b00};
            m_valid  = 1'b1;
            m_halted = 1'b0;
        end else if (m_valid && rdy) begin
            if (HALT_EN && word == HALT_WORD_TB) begin
                m_valid  = 1'b0;
                m_halted = 1'b1;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end else if (!m_valid && !m_halted) begin
            m_valid = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic run_until(input logic [31:0] target);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 64; i++) begin
            if (m_valid && m_pc == target) begin
                hit = 1'b1;
                break;
            end
            step(1'b1, 1'b0, 32'h0);
        end
        if (!hit) begin
            checks++;
            failures++;
            $display("FAIL reach_pc: got %h expected %h", m_pc, target);
        end
    endtask

    task automatic check_reset_state();
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, 32'h0);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_rom_addr", rom_addr, RESET_PC_TB);
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) rom_mem[k] = 32'(k) * 32'h11;
        rom_mem[8] = HALT_WORD_TB;
        model_reset();

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state();

        // Streaming from reset, then a 3-cycle stall at pc 8.
        run_until(32'h8);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 32'h0);
        chk("resume_pc", out_pc, 32'hC);

        // Redirect while flowing at 0x10; misaligned target.
        run_until(32'h10);
        step(1'b1, 1'b1, 32'h43);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // Run across the halt word at 0x20, then redirect to 0.
        step(1'b1, 1'b1, 32'h18);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0);
        chk("halt_state", {31'b0, halted}, {31'b0, HALT_EN});
        step(1'b1, 1'b1, 32'h0);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // Redirect while a word is parked.
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0);

        // Asynchronous reset mid-cycle.
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", {31'b0, out_valid}, 32'h0);
        chk("async_rst_pc", out_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_reset_state();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            bit          rdy;
            bit          rv;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 11) == 0);
            rpc = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : 32'($urandom);
            step(rdy, rv, rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
